main_mem_responder: RTL and testbench
=====================================

Name: main_mem_responder

Overview:
Backing-store responder for the data cache, which is the initiator on this interface. It accepts one load or store request at a time over a valid/ready handshake and services it after a fixed, parameterised latency. It returns load data, or a store acknowledgement, over a second valid/ready channel. The block holds the byte-addressed, little-endian main memory array and applies the same word/byte/halfword dataType encoding the datapath uses.

Parameters:
Data_Width, 32, data bus width; only 32 is supported.
Mem_Addr_Width, 12, number of byte-address bits decoded (4 KiB array); higher request address bits are ignored.
Latency, 3, cycles from request accept edge to response; must be >= 1.

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  1  initiator presents a request.
req_ready  output  1  responder can accept a request.
req_we  input  1  1 = store, 0 = load.
req_addr  input  Data_Width  byte address.
req_wdata  input  Data_Width  store data, right-aligned.
req_dataType  input  2  00 word, 01 byte, 10 halfword, 11 treated as word.
resp_valid  output  1  response available.
resp_ready  input  1  initiator takes the response.
resp_rdata  output  Data_Width  load data, zero-extended; 0 for stores.
busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, busy=0, latency counter=0.
- Reset and memory: array contents are not reset and are retained across reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On an edge with req_valid=1, latch we/addr/wdata/dataType, load counter=Latency-1, and go to WAIT.
- WAIT: req_ready=0. The counter decrements each edge. On the edge where counter==0, perform the access and go to RESP. All request inputs are ignored in WAIT (latched copies are used).
- Access timing: for a request accepted at edge k, the access occurs at edge k+Latency. resp_valid is first high in the cycle after that edge.
- RESP: resp_valid=1. resp_rdata is held stable until the handshake. On an edge with resp_ready=1, go to IDLE, clear resp_valid, and set req_ready=1.
- Throughput: with resp_ready tied high, the maximum rate is one transaction per Latency+2 cycles.
- Address decode: word index = addr[Mem_Addr_Width-1:2]; bits above Mem_Addr_Width are ignored, so addresses wrap modulo 2^Mem_Addr_Width.
- Word access: addr[1:0] is ignored (forced aligned). Reads return the full word; writes update all 4 lanes.
- Halfword access: addr[1] selects lane pair [15:0] or [31:16]; addr[0] is ignored. Writes update only that pair using wdata[15:0]. Reads return the selected pair zero-extended.
- Byte access: addr[1:0] selects the lane. Writes update only that lane using wdata[7:0]. Reads return the lane zero-extended.
- Store response: resp_rdata=0.
- Reset mid-transaction: return to IDLE immediately. A store whose access edge has not occurred is not committed. Any pending response is dropped.
- Simultaneous req_valid in RESP: not accepted (req_ready=0); the initiator must hold the request.
- Other request fields while req_valid=0: don't-care.

Test Plan:
1. Reset: hold rst_n=0 mid-clock -> immediately req_ready=1, resp_valid=0, resp_rdata=0, busy=0.
2. Latency and round trip (Latency=3): word store 0xDEADBEEF to 0x10 accepted at edge k -> resp_valid high after edge k+3 with rdata=0; then word load 0x10 -> 0xDEADBEEF returned exactly 3 edges after accept.
3. Sub-word access: byte store 0xAB to 0x13, then:
   - word load 0x10 -> 0xABADBEEF
   - byte load 0x13 -> 0x000000AB
   - half load 0x12 -> 0x0000ABAD
   - halfword store 0x1234 to 0x10, then word load -> 0xABAD1234
4. Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable, req_ready=0, a new req_valid is not accepted; raise resp_ready -> IDLE next edge, then the held request is accepted.
5. Address wrap and alignment: word store 0x11223344 to 0x1020 -> word load 0x20 returns 0x11223344; word load 0x22 also returns 0x11223344.
6. Reset mid-WAIT: store 0xFFFFFFFF to 0x40, then assert rst_n=0 one edge after accept -> FSM in IDLE; subsequent load 0x40 returns the prior contents.

Source files
------------

// File: rtl/main_mem_responder_if.sv
// main_mem_responder_if: request/response handshake between the data cache (master) and main memory (slave)
interface main_mem_responder_if #(
    parameter int Data_Width = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [Data_Width-1:0] req_addr;
    logic [Data_Width-1:0] req_wdata;
    logic [1:0]            req_dataType;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [Data_Width-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_dataType, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_dataType, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/main_mem_responder.sv
// main_mem_responder: fixed-latency byte-addressed little-endian load/store responder backing the data cache
module main_mem_responder #(
    parameter int Data_Width     = 32,
    parameter int Mem_Addr_Width = 12,
    parameter int Latency        = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    main_mem_responder_if.slave      bus,
    output logic                     busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam int Cnt_Width = (Latency > 1) ? $clog2(Latency) : 1;
    localparam int Idx_Width = Mem_Addr_Width - 2;
    localparam int Depth     = 1 << Idx_Width;

    logic [1:0]                state;
    logic [Cnt_Width-1:0]      cnt;
    logic                      we;
    logic [Mem_Addr_Width-1:0] addr;
    logic [Data_Width-1:0]     wdata;
    logic [1:0]                data_type;
    logic [Data_Width-1:0]     rdata;
    logic [Data_Width-1:0]     mem [Depth];
    logic [Idx_Width-1:0]      idx;
    logic [Data_Width-1:0]     word;
    logic                      access;
    logic                      is_byte;
    logic                      is_half;
    logic [3:0]                be;
    logic [Data_Width-1:0]     wword;
    logic [7:0]                lane_byte;
    logic [15:0]               lane_half;
    logic [Data_Width-1:0]     load_data;
    logic                      unused_addr;

    // Address bits above the decoded window wrap away by design.
    assign unused_addr = &{1'b0, bus.req_addr[Data_Width-1:Mem_Addr_Width]};

    assign idx     = addr[Mem_Addr_Width-1:2];
    assign word    = mem[idx];
    assign access  = (state == WAIT) && (cnt == '0);
    assign is_byte = data_type == 2'b01;
    assign is_half = data_type == 2'b10;

    // Lane enables, replicated store data and zero-extended load lane; dataType 11 behaves as word.
    always_comb begin
        be        = is_byte ? 4'b0001 << addr[1:0] : is_half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wword     = is_byte ? {4{wdata[7:0]}} : is_half ? {2{wdata[15:0]}} : wdata;
        lane_byte = word[8*addr[1:0] +: 8];
        lane_half = addr[1] ? word[31:16] : word[15:0];
        load_data = is_byte ? {24'd0, lane_byte} : is_half ? {16'd0, lane_half} : word;
    end

    // Memory array is never reset; a store commits only on its access edge, which reset suppresses via state.
    always_ff @(posedge clk) begin
        if (access && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    // Request latch, latency countdown and response hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rdata     <= '0;
            we        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            data_type <= 2'b00;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    state     <= WAIT;
                    cnt       <= Cnt_Width'(Latency - 1);
                    we        <= bus.req_we;
                    addr      <= bus.req_addr[Mem_Addr_Width-1:0];
                    wdata     <= bus.req_wdata;
                    data_type <= bus.req_dataType;
                end
                WAIT: if (cnt == '0) begin
                    state <= RESP;
                    rdata <= we ? '0 : load_data;
                end else begin
                    cnt <= cnt - Cnt_Width'(1);
                end
                RESP: if (bus.resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.resp_rdata = rdata;
    assign busy           = state != IDLE;
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: table-driven vectors plus hand-written backpressure and reset sequences
module tb_main_mem_responder;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    main_mem_responder_if #(.Data_Width(32)) bus ();

    main_mem_responder #(.Data_Width(32), .Mem_Addr_Width(12), .Latency(LAT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .busy(busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  dt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic present(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] dt);
        bus.req_we       = we;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_dataType = dt;
        bus.req_valid    = 1'b1;
    endtask

    task automatic wait_resp(output int lat);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] dt,
                        output logic [31:0] rd, output int lat);
        @(negedge clk);
        present(we, a, wd, dt);
        for (int n = 0; n < 20 && !bus.req_ready; n++) @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        wait_resp(lat);
        rd = bus.resp_rdata;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.req_dataType = 2'b00;
        bus.resp_ready   = 1'b0;

        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         2'b00, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 32'h0000_0013, 32'h0000_00AB, 2'b01, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         2'b00, 32'hABAD_BEEF});
        vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         2'b01, 32'h0000_00AB});
        vecs.push_back('{1'b0, 32'h0000_0012, 32'h0,         2'b10, 32'h0000_ABAD});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'h0000_1234, 2'b10, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         2'b00, 32'hABAD_1234});
        vecs.push_back('{1'b1, 32'h0000_1020, 32'h1122_3344, 2'b00, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         2'b00, 32'h1122_3344});
        vecs.push_back('{1'b0, 32'h0000_0022, 32'h0,         2'b00, 32'h1122_3344});
        vecs.push_back('{1'b0, 32'h0000_0021, 32'h0,         2'b01, 32'h0000_0033});
        vecs.push_back('{1'b0, 32'h0000_0023, 32'h0,         2'b10, 32'h0000_1122});
        vecs.push_back('{1'b0, 32'h0000_0023, 32'h0,         2'b11, 32'h1122_3344});
        vecs.push_back('{1'b1, 32'h0000_0021, 32'hFFFF_FF5A, 2'b01, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         2'b00, 32'h1122_5A44});
        vecs.push_back('{1'b1, 32'h0000_0023, 32'hFFFF_C0DE, 2'b10, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'hFFFF_F020, 32'h0,         2'b00, 32'hC0DE_5A44});
        vecs.push_back('{1'b1, 32'h0000_0040, 32'h0BAD_F00D, 2'b00, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h0000_0040, 32'h0,         2'b01, 32'h0000_000D});
        vecs.push_back('{1'b0, 32'h0000_0042, 32'h0,         2'b01, 32'h0000_00AD});

        // Reset state while rst_n is held low
        #12;
        check("rst req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst resp_rdata", bus.resp_rdata, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].dt, rd, lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(LAT));
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp);
            check($sformatf("vec%0d idle after", i), {30'd0, bus.req_ready, bus.resp_valid}, 32'd2);
        end

        // Backpressure: response held while a new request waits
        @(negedge clk);
        present(1'b0, 32'h10, 32'h0, 2'b00);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_resp(lat);
        check("bp latency", 32'(lat), 32'(LAT));
        present(1'b1, 32'h80, 32'h0000_0077, 2'b00);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp%0d resp_valid", c), {31'd0, bus.resp_valid}, 32'd1);
            check($sformatf("bp%0d rdata", c), bus.resp_rdata, 32'hABAD_1234);
            check($sformatf("bp%0d req_ready", c), {31'd0, bus.req_ready}, 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check("bp release idle", {30'd0, bus.req_ready, bus.resp_valid}, 32'd2);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("bp held accepted busy", {31'd0, busy}, 32'd1);
        wait_resp(lat);
        check("bp store latency", 32'(lat), 32'(LAT));
        check("bp store rdata", bus.resp_rdata, 32'd0);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        xact(1'b0, 32'h80, 32'h0, 2'b00, rd, lat);
        check("bp held store data", rd, 32'h0000_0077);

        // Reset mid-WAIT drops the pending store
        @(negedge clk);
        present(1'b1, 32'h40, 32'hFFFF_FFFF, 2'b00);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("mid busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid rst req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("mid rst busy", {31'd0, busy}, 32'd0);
        check("mid rst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("mid rst resp_rdata", bus.resp_rdata, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        xact(1'b0, 32'h40, 32'h0, 2'b00, rd, lat);
        check("mid rst store dropped", rd, 32'h0BAD_F00D);
        check("mid rst reload latency", 32'(lat), 32'(LAT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
